// File: rtl/xdisp_fifo_pkg.sv
// -----------------------------------------------------------------------------
// xdisp_pkg : shared definitions for the buffered display-output stage.
//   - default data width and FIFO depth
//   - drain FSM state encoding (IDLE, GAP, CR)
//   - status-word bit positions (for the default depth; status_bit() rebases
//     them for other depths)
//   - carriage-return / line-feed character codes
// Optional feature macro used by the stage: XDISP_FIFO_CRLF_EN.
// -----------------------------------------------------------------------------
package xdisp_pkg;

  localparam int DATA_W_DEF     = 12;
  localparam int DEPTH_LOG2_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_CR   = 2'd2
  } state_e;

  // Status word: count in [DEPTH_LOG2:0], then empty, full, ovf.
  localparam int CNT_LSB   = 0;
  localparam int EMPTY_BIT = CNT_LSB + DEPTH_LOG2_DEF + 1;
  localparam int FULL_BIT  = EMPTY_BIT + 1;
  localparam int OVF_BIT   = FULL_BIT + 1;

  localparam logic [DATA_W_DEF-1:0] CR_CODE = 12'h00D;
  localparam logic [DATA_W_DEF-1:0] LF_CODE = 12'h00A;

  // The flag positions move with the width of the count field.
  function automatic int status_bit(input int base_bit, input int depth_log2);
    return base_bit + depth_log2 - DEPTH_LOG2_DEF;
  endfunction

endpackage

// File: rtl/xdisp_fifo_if.sv
// -----------------------------------------------------------------------------
// xdisp_fifo_if : CPU-side and display-sink-side signals of xdisp_fifo.
//   sel, we, data_in : CPU select / write enable / write character
//   data_out         : registered status word returned to the CPU
//   disp_ready       : display sink may accept
//   disp_sel         : one-cycle strobe to display sink
//   disp_data        : character to display sink (valid with disp_sel)
// Modports: master (CPU + sink environment), slave (the FIFO stage).
// -----------------------------------------------------------------------------
interface xdisp_fifo_if
  import xdisp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              sel;
  logic              we;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              disp_ready;
  logic              disp_sel;
  logic [DATA_W-1:0] disp_data;

  modport master (
    output sel, we, data_in, disp_ready,
    input  data_out, disp_sel, disp_data
  );

  modport slave (
    input  sel, we, data_in, disp_ready,
    output data_out, disp_sel, disp_data
  );
endinterface

// File: rtl/xdisp_fifo_ram.sv
// -----------------------------------------------------------------------------
// xdisp_fifo_ram : DEPTH x DATA_W storage for xdisp_fifo.
//   clk      in  system clock
//   we_i     in  write strobe
//   waddr_i  in  write address
//   wdata_i  in  write data
//   raddr_i  in  read address
//   rdata_o  out read data (combinational from raddr_i)
// Contents are not reset; validity is tracked by the pointers/count in the top.
// -----------------------------------------------------------------------------
module xdisp_fifo_ram
  import xdisp_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [DATA_W-1:0]     rdata_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous read so the drain FSM sees the head entry in the same cycle.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/xdisp_fifo.sv
// -----------------------------------------------------------------------------
// xdisp_fifo : buffered character-output stage feeding the display sink.
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   bus  xdisp_fifo_if.slave
//        sel/we/data_in  -> CPU write pushes a character, CPU read (we=0)
//                           latches the status word into data_out
//        disp_ready      -> sink may accept
//        disp_sel/data   <- one-cycle strobe + character per emitted entry
// Status word: {0.., ovf, full, empty, count}; ovf is sticky, read-to-clear.
// Optional macro XDISP_FIFO_CRLF_EN: a line feed at the head is expanded to
// CR followed by LF (CR emitted without popping, LF popped from the CR state).
// -----------------------------------------------------------------------------
module xdisp_fifo
  import xdisp_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int GAP_CYCLES = 0
) (
  input logic         clk,
  input logic         rst,
  xdisp_fifo_if.slave bus
);
  localparam int  DEPTH     = 1 << DEPTH_LOG2;
  localparam int  CW        = DEPTH_LOG2 + 1;
  localparam int  GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam bit  HAS_GAP   = (GAP_CYCLES > 0);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam int  EMPTY_POS = status_bit(EMPTY_BIT, DEPTH_LOG2);
  localparam int  FULL_POS  = status_bit(FULL_BIT, DEPTH_LOG2);
  localparam int  OVF_POS   = status_bit(OVF_BIT, DEPTH_LOG2);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  ovf_q;
  state_e                state_q, state_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic                  disp_sel_q, disp_sel_d;
  logic [DATA_W-1:0]     disp_data_q, disp_data_d;
  logic [DATA_W-1:0]     data_out_q;
`ifdef XDISP_FIFO_CRLF_EN
  // Set while a GAP follows an emitted CR, so GAP returns to CR, not IDLE.
  logic                  cr_pend_q, cr_pend_d;
`endif

  logic              wr_req, rd_req, push, pop, overflow, empty, full, is_lf;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] status;

  assign wr_req   = bus.sel & bus.we;
  assign rd_req   = bus.sel & ~bus.we;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  // A write into a full FIFO is still taken when the drain pops on that edge.
  assign push     = wr_req & (~full | pop);
  assign overflow = wr_req & ~push;

`ifdef XDISP_FIFO_CRLF_EN
  assign is_lf = (head == DATA_W'(LF_CODE));
`else
  assign is_lf = 1'b0;
`endif

  xdisp_fifo_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  always_comb begin
    status                   = '0;
    status[CNT_LSB +: CW]    = count_q;
    status[EMPTY_POS]        = empty;
    status[FULL_POS]         = full;
    status[OVF_POS]          = ovf_q;
  end

  // Drain FSM next-state / outputs.
  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    disp_sel_d  = 1'b0;
    disp_data_d = disp_data_q;
    pop         = 1'b0;
`ifdef XDISP_FIFO_CRLF_EN
    cr_pend_d   = cr_pend_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!empty && bus.disp_ready) begin
          disp_sel_d = 1'b1;
          if (is_lf) begin
`ifdef XDISP_FIFO_CRLF_EN
            // Emit CR first; the LF stays at the head for the CR state.
            disp_data_d = DATA_W'(CR_CODE);
            if (HAS_GAP) begin
              state_d   = ST_GAP;
              gap_cnt_d = GAP_LOAD;
              cr_pend_d = 1'b1;
            end else begin
              state_d   = ST_CR;
            end
`endif
          end else begin
            disp_data_d = head;
            pop         = 1'b1;
            if (HAS_GAP) begin
              state_d   = ST_GAP;
              gap_cnt_d = GAP_LOAD;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
`ifdef XDISP_FIFO_CRLF_EN
          if (cr_pend_q) begin
            state_d = ST_CR;
          end
          cr_pend_d = 1'b0;
`endif
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
`ifdef XDISP_FIFO_CRLF_EN
      ST_CR: begin
        // The LF is still queued, so count is non-zero here.
        if (bus.disp_ready) begin
          disp_sel_d  = 1'b1;
          disp_data_d = head;
          pop         = 1'b1;
          if (HAS_GAP) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d   = ST_IDLE;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      state_q     <= ST_IDLE;
      gap_cnt_q   <= '0;
      disp_sel_q  <= 1'b0;
      disp_data_q <= '0;
      data_out_q  <= '0;
`ifdef XDISP_FIFO_CRLF_EN
      cr_pend_q   <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (rd_req) data_out_q <= status;
      // Read clears ovf, but an overflow on the same edge wins.
      ovf_q       <= (ovf_q & ~rd_req) | overflow;
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      disp_sel_q  <= disp_sel_d;
      disp_data_q <= disp_data_d;
`ifdef XDISP_FIFO_CRLF_EN
      cr_pend_q   <= cr_pend_d;
`endif
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.disp_sel  = disp_sel_q;
  assign bus.disp_data = disp_data_q;

endmodule

// File: tb/tb_xdisp_fifo.sv
// -----------------------------------------------------------------------------
// tb_xdisp_fifo : self-checking bench for xdisp_fifo.
// dut0 runs with GAP_CYCLES=0, dut1 with GAP_CYCLES=2. Emitted characters are
// checked against per-DUT expected queues filled when writes are driven.
// Honours XDISP_FIFO_CRLF_EN when computing expected output.
// -----------------------------------------------------------------------------
module tb_xdisp_fifo;
  import xdisp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xdisp_fifo_if #(.DATA_W(12)) bus0 ();
  xdisp_fifo_if #(.DATA_W(12)) bus1 ();

  xdisp_fifo #(.DEPTH_LOG2(4), .DATA_W(12), .GAP_CYCLES(0)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  xdisp_fifo #(.DEPTH_LOG2(4), .DATA_W(12), .GAP_CYCLES(2)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [11:0] exp_q0[$];
  logic [11:0] exp_q1[$];
  int          t0[$];
  int          t1[$];

  // Status word encodings for the default depth.
  localparam logic [11:0] ST_EMPTY    = 12'h020;
  localparam logic [11:0] ST_FULL     = 12'h050;
  localparam logic [11:0] ST_FULL_OVF = 12'h0D0;

  typedef struct {
    int          op;     // 1 = write, 2 = status read
    logic [11:0] din;
    logic        rdy;
    logic        acc;    // write expected to be accepted
    logic [11:0] exp_do; // expected status for reads
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus0.disp_sel === 1'b1) begin
      t0.push_back(cyc);
      if (exp_q0.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL strobe0_unexpected actual=%03h required=none", bus0.disp_data);
      end else begin
        logic [11:0] e;
        e = exp_q0.pop_front();
        chk("strobe0_data", int'(bus0.disp_data), int'(e));
        $display("dut0 emit %03h", bus0.disp_data);
      end
    end
    if (bus1.disp_sel === 1'b1) begin
      t1.push_back(cyc);
      if (exp_q1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL strobe1_unexpected actual=%03h required=none", bus1.disp_data);
      end else begin
        logic [11:0] e;
        e = exp_q1.pop_front();
        chk("strobe1_data", int'(bus1.disp_data), int'(e));
        $display("dut1 emit %03h", bus1.disp_data);
      end
    end
  end

  task automatic push_exp(input int which, input logic [11:0] d);
    logic [11:0] lf;
    logic [11:0] cr;
    lf = 12'h00A;
    cr = 12'h00D;
`ifdef XDISP_FIFO_CRLF_EN
    if (d == lf) begin
      if (which == 0) exp_q0.push_back(cr); else exp_q1.push_back(cr);
    end
`endif
    if (which == 0) exp_q0.push_back(d); else exp_q1.push_back(d);
  endtask

  task automatic wr0(input logic [11:0] d, input logic acc);
    @(negedge clk);
    bus0.sel = 1'b1; bus0.we = 1'b1; bus0.data_in = d;
    if (acc) push_exp(0, d);
    $display("dut0 write %03h", d);
  endtask

  task automatic wr1(input logic [11:0] d);
    @(negedge clk);
    bus1.sel = 1'b1; bus1.we = 1'b1; bus1.data_in = d;
    push_exp(1, d);
    $display("dut1 write %03h", d);
  endtask

  task automatic idle_all();
    @(negedge clk);
    bus0.sel = 1'b0; bus0.we = 1'b0;
    bus1.sel = 1'b0; bus1.we = 1'b0;
  endtask

  task automatic rd0(input string nm, input logic [11:0] req);
    @(negedge clk);
    bus0.sel = 1'b1; bus0.we = 1'b0;
    @(negedge clk);
    bus0.sel = 1'b0;
    $display("dut0 status %03h", bus0.data_out);
    chk(nm, int'(bus0.data_out), int'(req));
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int expect_n;
    bus0.sel = 0; bus0.we = 0; bus0.data_in = '0; bus0.disp_ready = 1;
    bus1.sel = 0; bus1.we = 0; bus1.data_in = '0; bus1.disp_ready = 1;

    // Reset state
    #12;
    chk("reset_data_out", int'(bus0.data_out), 0);
    chk("reset_disp_sel", int'(bus0.disp_sel), 0);
    chk("reset_disp_data", int'(bus0.disp_data), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: back-to-back strobes
    t0.delete();
    wr0(12'h041, 1'b1);
    wr0(12'h042, 1'b1);
    idle_all();
    wait_cyc(5);
    chk("t1_strobes", t0.size(), 2);
    if (t0.size() == 2) chk("t1_consecutive", t0[1] - t0[0], 1);
    rd0("t1_status", ST_EMPTY);

    // 2: GAP_CYCLES=2 spacing
    t1.delete();
    wr1(12'h031);
    wr1(12'h032);
    wr1(12'h033);
    idle_all();
    wait_cyc(15);
    chk("t2_strobes", t1.size(), 3);
    if (t1.size() == 3) begin
      chk("t2_gap_a", t1[1] - t1[0], 3);
      chk("t2_gap_b", t1[2] - t1[1], 3);
    end
    chk("t2_queue_empty", exp_q1.size(), 0);

    // 3: overflow, read-to-clear, drain (table-driven)
    for (int i = 0; i < 17; i++)
      vecs.push_back('{op: 1, din: 12'(12'h061 + i), rdy: 1'b0, acc: (i < 16), exp_do: 12'h000});
    vecs.push_back('{op: 2, din: 12'h000, rdy: 1'b0, acc: 1'b0, exp_do: ST_FULL_OVF});
    vecs.push_back('{op: 2, din: 12'h000, rdy: 1'b0, acc: 1'b0, exp_do: ST_FULL});
    bus0.disp_ready = 1'b0;
    foreach (vecs[i]) begin
      bus0.disp_ready = vecs[i].rdy;
      if (vecs[i].op == 1) wr0(vecs[i].din, vecs[i].acc);
      else begin
        idle_all();
        rd0($sformatf("t3_vec%0d_status", i), vecs[i].exp_do);
      end
    end
    idle_all();
    t0.delete();
    bus0.disp_ready = 1'b1;
    wait_cyc(22);
    chk("t3_drained", t0.size(), 16);
    if (t0.size() == 16) chk("t3_contiguous", t0[15] - t0[0], 15);
    chk("t3_queue_empty", exp_q0.size(), 0);
    rd0("t3_status_after", ST_EMPTY);

    // 4: write into full FIFO on the pop edge
    bus0.disp_ready = 1'b0;
    for (int i = 0; i < 16; i++) wr0(12'(12'h080 + i), 1'b1);
    idle_all();
    rd0("t4_full", ST_FULL);
    @(negedge clk);
    bus0.disp_ready = 1'b1;
    bus0.sel = 1'b1; bus0.we = 1'b1; bus0.data_in = 12'h0AA;
    push_exp(0, 12'h0AA);
    @(negedge clk);
    bus0.disp_ready = 1'b0;
    bus0.sel = 1'b0; bus0.we = 1'b0;
    rd0("t4_accept_no_ovf", ST_FULL);
    bus0.disp_ready = 1'b1;
    wait_cyc(22);
    chk("t4_queue_empty", exp_q0.size(), 0);
    rd0("t4_status_after", ST_EMPTY);

    // 5: asynchronous reset mid-drain
    bus0.disp_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr0(12'(12'h090 + i), 1'b1);
    idle_all();
    @(negedge clk);
    bus0.disp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_sel_async", int'(bus0.disp_sel), 0);
    exp_q0.delete();
    t0.delete();
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(10);
    chk("t5_no_strobes", t0.size(), 0);
    rd0("t5_status", ST_EMPTY);

    // 6: line feed handling
    t0.delete();
    wr0(12'h048, 1'b1);
    wr0(12'h00A, 1'b1);
    idle_all();
    wait_cyc(8);
`ifdef XDISP_FIFO_CRLF_EN
    expect_n = 3;
`else
    expect_n = 2;
`endif
    chk("t6_strobes", t0.size(), expect_n);
    chk("t6_queue_empty", exp_q0.size(), 0);
    wr1(12'h00A);
    wr1(12'h043);
    idle_all();
    wait_cyc(16);
    chk("t6_gap_queue_empty", exp_q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
